// File: rtl/sport_slave_rx_if.sv
// sport_slave_rx_if: pins, static configuration and holding-register status of the SPORT slave receiver
interface sport_slave_rx_if #(parameter int WMAX = 16);
  logic SP_EN, SCLK_PIN, RFS_PIN, DR_PIN, INVSCLK, INVRFS, MSB_FIRST, RX_RD;
  logic [4:0] SLEN;
  logic [1:0] FSD;
  logic [WMAX-1:0] RX_DATA;
  logic RX_FULL, RX_VALID, RX_OVF, FS_ERR, SCLK_LOST;
  modport master(
    output SP_EN, SCLK_PIN, RFS_PIN, DR_PIN, INVSCLK, INVRFS, MSB_FIRST, RX_RD, SLEN, FSD,
    input RX_DATA, RX_FULL, RX_VALID, RX_OVF, FS_ERR, SCLK_LOST
  );
  modport slave(
    input SP_EN, SCLK_PIN, RFS_PIN, DR_PIN, INVSCLK, INVRFS, MSB_FIRST, RX_RD, SLEN, FSD,
    output RX_DATA, RX_FULL, RX_VALID, RX_OVF, FS_ERR, SCLK_LOST
  );
endinterface

// File: rtl/sport_slave_rx.sv
// sport_slave_rx: oversampling SPORT slave receiver with single-entry holding register
module sport_slave_rx #(
  parameter int TIMEOUT = 255,
  parameter int WMAX = 16
) (
  input logic DSPCLK,
  input logic RST,
  sport_slave_rx_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DELAY, SHIFT} state_t;
  state_t state, state_n;
  logic sclk_s1, sclk_s2, sclk_h, rfs_s1, rfs_s2, dr_s1, dr_s2, fs_prev, done, done_n;
  logic se, fs, start, final_bit, timeout, fs_err_set, lost_set;
  logic [1:0] dcnt, dcnt_n;
  logic [4:0] bitcnt, bitcnt_n, len;
  logic [WMAX-1:0] sreg, sreg_n, word, word_n;
  logic [15:0] wdog;
  assign se = (sclk_s2 ^ bus.INVSCLK) & ~(sclk_h ^ bus.INVSCLK);
  assign fs = rfs_s2 ^ bus.INVRFS;
  assign start = se & fs & ~fs_prev;
  assign len = bus.SLEN < 5'd2 ? 5'd3 : bus.SLEN > 5'd15 ? 5'd16 : bus.SLEN + 5'd1;
  assign final_bit = bitcnt == len - 5'd1;
  assign timeout = state != IDLE && wdog == 16'(TIMEOUT);
  // the completed word is latched into word_n before a same-edge frame start reuses sreg_n
  always_comb begin
    state_n = state;
    dcnt_n = dcnt;
    bitcnt_n = bitcnt;
    sreg_n = sreg;
    word_n = word;
    done_n = 1'b0;
    fs_err_set = 1'b0;
    lost_set = 1'b0;
    if (!bus.SP_EN) state_n = IDLE;
    else if (timeout) begin
      state_n = IDLE;
      lost_set = 1'b1;
    end else if (se) begin
      if (state == DELAY && !start) begin
        dcnt_n = dcnt - 2'd1;
        if (dcnt == 2'd1) begin
          state_n = SHIFT;
          bitcnt_n = 5'd1;
          sreg_n = WMAX'(dr_s2);
        end
      end else if (state == SHIFT && !(start && !final_bit)) begin
        bitcnt_n = bitcnt + 5'd1;
        sreg_n = bus.MSB_FIRST ? {sreg[WMAX-2:0], dr_s2} : sreg | (WMAX'(dr_s2) << bitcnt);
        if (final_bit) begin
          state_n = IDLE;
          done_n = 1'b1;
          word_n = sreg_n;
        end
      end
      if (start) begin
        fs_err_set = state == DELAY || (state == SHIFT && !final_bit);
        state_n = bus.FSD == 2'd0 ? SHIFT : DELAY;
        dcnt_n = bus.FSD;
        bitcnt_n = 5'd1;
        sreg_n = WMAX'(dr_s2);
      end
    end
  end
  always_ff @(posedge DSPCLK or posedge RST) begin
    if (RST) begin
      {sclk_s1, sclk_s2, sclk_h, rfs_s1, rfs_s2, dr_s1, dr_s2, fs_prev, done} <= '0;
      state <= IDLE;
      dcnt <= '0;
      bitcnt <= '0;
      sreg <= '0;
      word <= '0;
      wdog <= '0;
      bus.RX_DATA <= '0;
      {bus.RX_FULL, bus.RX_VALID, bus.RX_OVF, bus.FS_ERR, bus.SCLK_LOST} <= '0;
    end else begin
      {sclk_s1, sclk_s2, sclk_h} <= {bus.SCLK_PIN, sclk_s1, sclk_s2};
      {rfs_s1, rfs_s2} <= {bus.RFS_PIN, rfs_s1};
      {dr_s1, dr_s2} <= {bus.DR_PIN, dr_s1};
      state <= state_n;
      dcnt <= dcnt_n;
      bitcnt <= bitcnt_n;
      sreg <= sreg_n;
      word <= word_n;
      done <= done_n;
      fs_prev <= !bus.SP_EN ? 1'b1 : se ? fs : fs_prev;
      wdog <= (state == IDLE || se) ? 16'd0 : wdog == 16'hffff ? wdog : wdog + 16'd1;
      bus.RX_VALID <= bus.SP_EN & done & (~bus.RX_FULL | bus.RX_RD);
      if (!bus.SP_EN) {bus.RX_FULL, bus.RX_OVF, bus.FS_ERR, bus.SCLK_LOST} <= '0;
      else begin
        if (done && (!bus.RX_FULL || bus.RX_RD)) begin
          bus.RX_DATA <= word;
          bus.RX_FULL <= 1'b1;
        end else if (done) bus.RX_OVF <= 1'b1;
        else if (bus.RX_RD) bus.RX_FULL <= 1'b0;
        if (fs_err_set) bus.FS_ERR <= 1'b1;
        if (lost_set) bus.SCLK_LOST <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sport_slave_rx.sv
// tb_sport_slave_rx: directed and randomized frames checked against a word-level receiver model
module tb_sport_slave_rx;
  localparam int TO = 20;
  logic DSPCLK = 1'b0;
  logic RST = 1'b1;
  int errs = 0, checks = 0, vcnt = 0;
  logic [15:0] m_data = '0;
  bit m_full = 0, m_ovf = 0;
  sport_slave_rx_if b();
  sport_slave_rx #(.TIMEOUT(TO)) dut(.DSPCLK(DSPCLK), .RST(RST), .bus(b));
  always #5 DSPCLK = ~DSPCLK;
  always @(posedge DSPCLK) if (b.RX_VALID === 1'b1) vcnt++;
  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  function automatic int leff(input logic [4:0] s);
    return s < 5'd2 ? 3 : s > 5'd15 ? 16 : int'(s) + 1;
  endfunction
  task automatic tick(input int n);
    repeat (n) @(negedge DSPCLK);
  endtask
  // one effective SCLK period: low 4 cycles with data/fs, then high 4; rd lands in the load cycle
  task automatic send_bit(input bit f, input bit d, input bit rd);
    @(negedge DSPCLK);
    b.RX_RD = 1'b0;
    b.SCLK_PIN = b.INVSCLK;
    b.RFS_PIN = f ^ b.INVRFS;
    b.DR_PIN = d;
    tick(3);
    @(negedge DSPCLK);
    b.SCLK_PIN = ~b.INVSCLK;
    tick(2);
    @(negedge DSPCLK);
    b.RX_RD = rd;
  endtask
  task automatic send_frame(input logic [15:0] v, input int nsend, input bit rd);
    int l, n, i;
    bit d;
    l = leff(b.SLEN);
    n = int'(b.FSD) + nsend;
    for (int e = 0; e < n; e++) begin
      i = e - int'(b.FSD);
      d = i < 0 ? 1'($urandom) : b.MSB_FIRST ? v[l-1-i] : v[i];
      send_bit(e == 0, d, rd && e == n - 1);
    end
  endtask
  task automatic settle();
    @(negedge DSPCLK);
    b.RX_RD = 1'b0;
    b.SCLK_PIN = b.INVSCLK;
    @(negedge DSPCLK);
  endtask
  task automatic rd_pulse();
    @(negedge DSPCLK);
    b.RX_RD = 1'b1;
    @(negedge DSPCLK);
    b.RX_RD = 1'b0;
    @(negedge DSPCLK);
  endtask
  task automatic cfg(input logic [4:0] slen, input logic [1:0] fsd, input bit msb, input bit invs, input bit invr);
    @(negedge DSPCLK);
    b.SP_EN = 1'b0;
    b.RX_RD = 1'b0;
    b.SLEN = slen;
    b.FSD = fsd;
    b.MSB_FIRST = msb;
    b.INVSCLK = invs;
    b.INVRFS = invr;
    b.SCLK_PIN = invs;
    b.RFS_PIN = invr;
    b.DR_PIN = 1'b0;
    tick(4);
    b.SP_EN = 1'b1;
    m_full = 0;
    m_ovf = 0;
    send_bit(0, 0, 0);
  endtask
  task automatic test_reset();
    tick(2);
    checks++;
    if ({b.RX_DATA, b.RX_FULL, b.RX_VALID, b.RX_OVF, b.FS_ERR, b.SCLK_LOST} !== 21'd0)
      begin errs++; $display("FAIL reset_in: got %h expected 0", {b.RX_DATA, b.RX_FULL, b.RX_VALID, b.RX_OVF, b.FS_ERR, b.SCLK_LOST}); end
    RST = 1'b0;
    tick(3);
    checks++;
    if ({b.RX_DATA, b.RX_FULL, b.RX_VALID, b.RX_OVF, b.FS_ERR, b.SCLK_LOST} !== 21'd0)
      begin errs++; $display("FAIL reset_out: got %h expected 0", {b.RX_DATA, b.RX_FULL, b.RX_VALID, b.RX_OVF, b.FS_ERR, b.SCLK_LOST}); end
  endtask
  task automatic test_basic();
    int v0;
    cfg(7, 0, 1, 0, 0);
    v0 = vcnt;
    send_frame(16'h00A5, 8, 0);
    @(negedge DSPCLK);
    b.SCLK_PIN = b.INVSCLK;
    checks++;
    if (b.RX_VALID !== 1'b1) begin errs++; $display("FAIL basic_valid_latency: got %b expected 1", b.RX_VALID); end
    @(negedge DSPCLK);
    checks++;
    if (b.RX_VALID !== 1'b0) begin errs++; $display("FAIL basic_valid_width: got %b expected 0", b.RX_VALID); end
    checks++;
    if ({b.RX_DATA, b.RX_FULL} !== {16'h00A5, 1'b1}) begin errs++; $display("FAIL basic_data: got %h/%b expected 00a5/1", b.RX_DATA, b.RX_FULL); end
    checks++;
    if (vcnt - v0 != 1) begin errs++; $display("FAIL basic_vcount: got %0d expected 1", vcnt - v0); end
  endtask
  task automatic test_lsb_inv();
    cfg(15, 1, 0, 1, 1);
    send_frame(16'h1234, 16, 0);
    settle();
    checks++;
    if ({b.RX_DATA, b.RX_FULL} !== {16'h1234, 1'b1}) begin errs++; $display("FAIL lsb_inv: got %h/%b expected 1234/1", b.RX_DATA, b.RX_FULL); end
  endtask
  task automatic test_back_to_back();
    int v0;
    cfg(7, 0, 1, 0, 0);
    v0 = vcnt;
    send_frame(16'h11, 8, 0);
    send_frame(16'h22, 8, 0);
    settle();
    checks++;
    if ({b.RX_DATA, b.RX_FULL, b.RX_OVF} !== {16'h0011, 2'b11}) begin errs++; $display("FAIL ovf_hold: got %h/%b/%b expected 0011/1/1", b.RX_DATA, b.RX_FULL, b.RX_OVF); end
    checks++;
    if (vcnt - v0 != 1) begin errs++; $display("FAIL ovf_vcount: got %0d expected 1", vcnt - v0); end
    rd_pulse();
    checks++;
    if ({b.RX_FULL, b.RX_OVF} !== 2'b01) begin errs++; $display("FAIL ovf_read: got full=%b ovf=%b expected 0/1", b.RX_FULL, b.RX_OVF); end
    cfg(7, 0, 1, 0, 0);
    send_frame(16'h11, 8, 0);
    send_frame(16'h22, 8, 1);
    settle();
    checks++;
    if ({b.RX_DATA, b.RX_FULL, b.RX_OVF} !== {16'h0022, 2'b10}) begin errs++; $display("FAIL rd_in_load: got %h/%b/%b expected 0022/1/0", b.RX_DATA, b.RX_FULL, b.RX_OVF); end
  endtask
  task automatic test_fs_err();
    int v0;
    cfg(7, 0, 1, 0, 0);
    v0 = vcnt;
    send_frame(16'hFF, 4, 0);
    send_frame(16'hC3, 8, 0);
    settle();
    checks++;
    if ({b.RX_DATA, b.FS_ERR} !== {16'h00C3, 1'b1}) begin errs++; $display("FAIL fs_err: got %h/%b expected 00c3/1", b.RX_DATA, b.FS_ERR); end
    checks++;
    if (vcnt - v0 != 1) begin errs++; $display("FAIL fs_err_vcount: got %0d expected 1", vcnt - v0); end
  endtask
  task automatic test_timeout();
    int v0;
    cfg(7, 0, 1, 0, 0);
    v0 = vcnt;
    send_frame(16'hA0, 3, 0);
    @(negedge DSPCLK);
    b.SCLK_PIN = b.INVSCLK;
    tick(14);
    checks++;
    if (b.SCLK_LOST !== 1'b0) begin errs++; $display("FAIL lost_early: got %b expected 0", b.SCLK_LOST); end
    for (int k = 0; k < 15 && b.SCLK_LOST !== 1'b1; k++) tick(1);
    checks++;
    if ({b.SCLK_LOST, b.RX_FULL} !== 2'b10) begin errs++; $display("FAIL lost_set: got lost=%b full=%b expected 1/0", b.SCLK_LOST, b.RX_FULL); end
    checks++;
    if (vcnt != v0) begin errs++; $display("FAIL lost_vcount: got %0d expected 0", vcnt - v0); end
    send_frame(16'h5A, 8, 0);
    settle();
    checks++;
    if (b.RX_DATA !== 16'h005A) begin errs++; $display("FAIL lost_recover: got %h expected 005a", b.RX_DATA); end
  endtask
  task automatic test_short_and_rst();
    int v0;
    cfg(1, 0, 1, 0, 0);
    send_frame(16'h5, 3, 0);
    settle();
    checks++;
    if ({b.RX_DATA, b.RX_FULL} !== {16'h0005, 1'b1}) begin errs++; $display("FAIL short_word: got %h/%b expected 0005/1", b.RX_DATA, b.RX_FULL); end
    cfg(7, 0, 1, 0, 0);
    send_frame(16'h3C, 8, 0);
    settle();
    v0 = vcnt;
    send_frame(16'hFF, 5, 0);
    @(negedge DSPCLK);
    RST = 1'b1;
    @(negedge DSPCLK);
    checks++;
    if ({b.RX_DATA, b.RX_FULL, b.RX_VALID, b.RX_OVF, b.FS_ERR, b.SCLK_LOST} !== 21'd0)
      begin errs++; $display("FAIL rst_mid_word: got %h expected 0", {b.RX_DATA, b.RX_FULL, b.RX_VALID, b.RX_OVF, b.FS_ERR, b.SCLK_LOST}); end
    RST = 1'b0;
    b.SCLK_PIN = b.INVSCLK;
    tick(40);
    checks++;
    if (vcnt != v0 || b.RX_FULL !== 1'b0) begin errs++; $display("FAIL rst_no_valid: got vcount %0d full %b expected 0/0", vcnt - v0, b.RX_FULL); end
    m_data = '0;
  endtask
  task automatic test_disable();
    cfg(7, 0, 1, 0, 0);
    send_frame(16'h77, 8, 0);
    send_frame(16'h66, 8, 0);
    send_frame(16'hFF, 4, 0);
    send_frame(16'h55, 8, 0);
    send_frame(16'hFF, 3, 0);
    @(negedge DSPCLK);
    b.SCLK_PIN = b.INVSCLK;
    tick(30);
    checks++;
    if ({b.RX_FULL, b.RX_OVF, b.FS_ERR, b.SCLK_LOST} !== 4'hF) begin errs++; $display("FAIL flags_set: got %b expected 1111", {b.RX_FULL, b.RX_OVF, b.FS_ERR, b.SCLK_LOST}); end
    @(negedge DSPCLK);
    b.SP_EN = 1'b0;
    tick(2);
    checks++;
    if ({b.RX_DATA, b.RX_FULL, b.RX_OVF, b.FS_ERR, b.SCLK_LOST} !== {16'h0077, 4'h0}) begin errs++; $display("FAIL disable_clear: got %h expected 00770", {b.RX_DATA, b.RX_FULL, b.RX_OVF, b.FS_ERR, b.SCLK_LOST}); end
    m_data = 16'h0077;
  endtask
  task automatic test_random();
    int l, mode, v0;
    logic [15:0] v;
    for (int it = 0; it < 12; it++) begin
      cfg(5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom));
      l = leff(b.SLEN);
      for (int f = 0; f < 3; f++) begin
        mode = $urandom_range(0, 2);
        if (mode == 2) begin rd_pulse(); m_full = 0; end
        v = 16'($urandom) & 16'((32'd1 << l) - 1);
        v0 = vcnt;
        send_frame(v, l, mode == 1);
        settle();
        if (!m_full || mode == 1) begin m_data = v; m_full = 1; end
        else m_ovf = 1;
        checks++;
        if ({b.RX_DATA, b.RX_FULL, b.RX_OVF, b.FS_ERR} !== {m_data, m_full, m_ovf, 1'b0})
          begin errs++; $display("FAIL rand_%0d_%0d: got %h/%b/%b/%b expected %h/%b/%b/0", it, f, b.RX_DATA, b.RX_FULL, b.RX_OVF, b.FS_ERR, m_data, m_full, m_ovf); end
      end
    end
  endtask
  initial begin
    b.SP_EN = 1'b0;
    b.SCLK_PIN = 1'b0;
    b.RFS_PIN = 1'b0;
    b.DR_PIN = 1'b0;
    b.INVSCLK = 1'b0;
    b.INVRFS = 1'b0;
    b.MSB_FIRST = 1'b1;
    b.RX_RD = 1'b0;
    b.SLEN = 5'd7;
    b.FSD = 2'd0;
    test_reset();
    test_basic();
    test_lsb_inv();
    test_back_to_back();
    test_fs_err();
    test_timeout();
    test_short_and_rst();
    test_disable();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
